// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM duty-cycle stage.
// The FSM state encoding and the period length live here so every file agrees on them.
package pwm_pkg;

   localparam int PWM_N_DEFAULT = 4;

   typedef enum logic [1:0] {
      OFF,
      ARM,
      RUN,
      DRAIN
   } pwm_state_t;

   // Last count value of a 2^n-clock period.
   function automatic int period_max(input int n);
      return (32'sd1 <<< n) - 32'sd1;
   endfunction

endpackage

// File: rtl/pwm_gen_if.sv
// Bundle between the upstream counter/control side (master) and the PWM stage (slave).
interface pwm_gen_if
   import pwm_pkg::*;
#(
   parameter int N = PWM_N_DEFAULT
) ();

   logic [N-1:0] cnt;
   logic         enable;
   logic [N-1:0] duty;
   logic         duty_load;
   logic         pwm_out;
   logic         period_done;
   logic         duty_pending;
   logic         active;

   modport master (
      output cnt,
      output enable,
      output duty,
      output duty_load,
      input  pwm_out,
      input  period_done,
      input  duty_pending,
      input  active
   );

   modport slave (
      input  cnt,
      input  enable,
      input  duty,
      input  duty_load,
      output pwm_out,
      output period_done,
      output duty_pending,
      output active
   );

endinterface

// File: rtl/duty_shadow.sv
// Double-buffered duty register: a pending value captured on load and an active value
// that only changes at a period start, with a same-cycle bypass for loads at the start.
module duty_shadow
   import pwm_pkg::*;
#(
   parameter int N = PWM_N_DEFAULT
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         i_start,
   input  logic         i_load,
   input  logic [N-1:0] i_duty,
   output logic [N-1:0] o_eff_duty,
   output logic         o_pending
);

   logic [N-1:0] r_pend_duty;
   logic [N-1:0] r_act_duty;
   logic         r_pending;
   logic [N-1:0] w_start_duty;

   assign w_start_duty = i_load ? i_duty : r_pend_duty;
   assign o_eff_duty   = i_start ? w_start_duty : r_act_duty;
   assign o_pending    = r_pending;

   // The pending copy follows a bypassed load too, so a later start with no new load
   // re-applies the same value instead of resurrecting an older one.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pend_duty <= '0;
         r_act_duty  <= '0;
         r_pending   <= 1'b0;
      end else if (i_start) begin
         r_pend_duty <= w_start_duty;
         r_act_duty  <= w_start_duty;
         r_pending   <= 1'b0;
      end else if (i_load) begin
         r_pend_duty <= i_duty;
         r_pending   <= 1'b1;
      end
   end

endmodule

// File: rtl/pwm_gen.sv
// PWM stage fed by a free-running counter: compares the count against a shadowed duty
// and gates the output with an FSM so periods start and end on the counter wrap.
module pwm_gen
   import pwm_pkg::*;
#(
   parameter int N = PWM_N_DEFAULT
) (
   input  logic     clock,
   input  logic     reset,
   pwm_gen_if.slave io_pwm
);

   localparam logic [N-1:0] P_MAX = N'(period_max(N));

   pwm_state_t   r_state;
   pwm_state_t   w_state_next;
   logic         r_pwm_out;
   logic         r_period_done;
   logic         w_cnt_zero;
   logic         w_cnt_max;
   logic         w_start;
   logic         w_running;
   logic         w_out_on;
   logic         w_pwm_next;
   logic         w_done_next;
   logic         w_pending;
   logic [N-1:0] w_eff_duty;

   assign w_cnt_zero = (io_pwm.cnt == '0);
   assign w_cnt_max  = (io_pwm.cnt == P_MAX);
   assign w_running  = (r_state == RUN) || (r_state == DRAIN);
   assign w_start    = w_cnt_zero && (r_state != OFF);

   duty_shadow #(
      .N(N)
   ) u_duty_shadow (
      .clock      (clock),
      .reset      (reset),
      .i_start    (w_start),
      .i_load     (io_pwm.duty_load),
      .i_duty     (io_pwm.duty),
      .o_eff_duty (w_eff_duty),
      .o_pending  (w_pending)
   );

   // Dropping enable on the last count of a period has already completed it, so RUN
   // goes straight to OFF there rather than draining a whole extra period.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         OFF: begin
            if (io_pwm.enable) w_state_next = ARM;
         end
         ARM: begin
            if (!io_pwm.enable)  w_state_next = OFF;
            else if (w_cnt_zero) w_state_next = RUN;
         end
         RUN: begin
            if (!io_pwm.enable) w_state_next = w_cnt_max ? OFF : DRAIN;
         end
         DRAIN: begin
            if (io_pwm.enable)  w_state_next = RUN;
            else if (w_cnt_max) w_state_next = OFF;
         end
         default: w_state_next = OFF;
      endcase
   end

   // Gating on the next state lets the ARM->RUN wrap cycle produce the first high clock,
   // so the first output period is full length.
   assign w_out_on    = (w_state_next == RUN) || (w_state_next == DRAIN);
   assign w_pwm_next  = w_out_on && (io_pwm.cnt < w_eff_duty);
   assign w_done_next = w_running && w_cnt_max;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= OFF;
         r_pwm_out     <= 1'b0;
         r_period_done <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_pwm_out     <= w_pwm_next;
         r_period_done <= w_done_next;
      end
   end

   assign io_pwm.pwm_out      = r_pwm_out;
   assign io_pwm.period_done  = r_period_done;
   assign io_pwm.duty_pending = w_pending;
   assign io_pwm.active       = w_running;

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen: whole-period vectors from a table, plus hand-written
// sequences for counter hold and mid-period reset.
module tb_pwm_gen;
   import pwm_pkg::*;

   localparam int N = 4;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   pwm_gen_if #(.N(N)) bus ();

   pwm_gen #(.N(N)) dut (
      .clock  (clock),
      .reset  (reset),
      .io_pwm (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // One record describes one 16-clock period, counter going 0..15.
   typedef struct {
      logic       en;
      int         drop_at;
      int         raise_at;
      int         load_at;
      logic [3:0] load_val;
      int         exp_high;
      int         exp_done;
      int         exp_pend;
      int         exp_active;
   } vec_t;

   vec_t vecs [18];
   vec_t tail [3];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input int c, input logic en, input logic ld,
                        input logic [3:0] d, input logic rst);
      bus.cnt       = 4'(c);
      bus.enable    = en;
      bus.duty_load = ld;
      bus.duty      = d;
      reset         = rst;
      tick();
   endtask

   task automatic run_period(input vec_t v, input string tag);
      int   highs     = 0;
      int   prefix    = 0;
      int   dones     = 0;
      int   pend_seen = 0;
      bit   in_prefix = 1'b1;
      logic en;
      for (int c = 0; c < 16; c++) begin
         en = v.en;
         if (v.drop_at >= 0 && c >= v.drop_at) en = 1'b0;
         if (v.raise_at >= 0 && c >= v.raise_at) en = 1'b1;
         drive(c, en, (c == v.load_at), (c == v.load_at) ? v.load_val : 4'hA, 1'b0);
         if (bus.pwm_out === 1'b1) highs++;
         if (bus.pwm_out === 1'b1 && in_prefix) prefix++;
         else in_prefix = 1'b0;
         if (bus.period_done === 1'b1) dones++;
         if (bus.duty_pending === 1'b1) pend_seen = 1;
      end
      bus.duty_load = 1'b0;
      check({tag, "_high"},   highs,             v.exp_high);
      check({tag, "_prefix"}, prefix,            v.exp_high);
      check({tag, "_done"},   dones,             v.exp_done);
      check({tag, "_pend"},   pend_seen,         v.exp_pend);
      check({tag, "_active"}, 32'(bus.active),   v.exp_active);
      $display("period %s: high=%0d done=%0d pend_seen=%0d active=%0d",
               tag, highs, dones, pend_seen, bus.active);
   endtask

   initial begin
      int highs;

      //           en    drop rise load val     high done pend act
      vecs[0]  = '{1'b1, -1, -1,  8, 4'd5,    0,   0,   1,   0};  // arm, preload 5
      vecs[1]  = '{1'b1, -1, -1, -1, 4'd0,    5,   1,   0,   1};
      vecs[2]  = '{1'b1, -1, -1, -1, 4'd0,    5,   1,   0,   1};
      vecs[3]  = '{1'b1, -1, -1,  7, 4'd12,   5,   1,   1,   1};  // mid-period load
      vecs[4]  = '{1'b1, -1, -1, -1, 4'd0,   12,   1,   0,   1};
      vecs[5]  = '{1'b1, -1, -1,  0, 4'd9,    9,   1,   0,   1};  // same-cycle load
      vecs[6]  = '{1'b1, -1, -1, -1, 4'd0,    9,   1,   0,   1};
      vecs[7]  = '{1'b1,  3, -1, -1, 4'd0,    9,   1,   0,   0};  // drain
      vecs[8]  = '{1'b0, -1, -1, -1, 4'd0,    0,   0,   0,   0};
      vecs[9]  = '{1'b1, -1, -1, -1, 4'd0,    0,   0,   0,   0};  // re-arm
      vecs[10] = '{1'b1, -1, -1, -1, 4'd0,    9,   1,   0,   1};
      vecs[11] = '{1'b1,  2,  6, -1, 4'd0,    9,   1,   0,   1};  // re-raise in drain
      vecs[12] = '{1'b1, -1, -1, -1, 4'd0,    9,   1,   0,   1};
      vecs[13] = '{1'b1, -1, -1, 10, 4'd0,    9,   1,   1,   1};
      vecs[14] = '{1'b1, -1, -1, -1, 4'd0,    0,   1,   0,   1};  // duty 0
      vecs[15] = '{1'b1, -1, -1,  5, 4'd15,   0,   1,   1,   1};
      vecs[16] = '{1'b1, -1, -1, -1, 4'd0,   15,   1,   0,   1};  // duty 15
      vecs[17] = '{1'b1, -1, -1, -1, 4'd0,   15,   1,   0,   1};

      tail[0]  = '{1'b1, -1, -1, -1, 4'd0,    0,   1,   0,   1};  // act_duty cleared
      tail[1]  = '{1'b1, -1, -1,  3, 4'd10,   0,   1,   1,   1};
      tail[2]  = '{1'b1, -1, -1, -1, 4'd0,   10,   1,   0,   1};

      bus.cnt       = '0;
      bus.enable    = 1'b0;
      bus.duty      = '0;
      bus.duty_load = 1'b0;
      reset         = 1'b1;

      // Reset held with enable and a load strobe active: everything stays 0.
      for (int i = 0; i < 3; i++) begin
         drive(0, 1'b1, 1'b1, 4'd5, 1'b1);
         check($sformatf("rst%0d_pwm", i),    32'(bus.pwm_out),      0);
         check($sformatf("rst%0d_done", i),   32'(bus.period_done),  0);
         check($sformatf("rst%0d_pend", i),   32'(bus.duty_pending), 0);
         check($sformatf("rst%0d_active", i), 32'(bus.active),      0);
         $display("reset cycle %0d: pwm=%0d done=%0d pend=%0d active=%0d",
                  i, bus.pwm_out, bus.period_done, bus.duty_pending, bus.active);
      end
      reset = 1'b0;

      foreach (vecs[i]) run_period(vecs[i], $sformatf("v%0d", i));

      // Counter held at 0 while running with duty 15: repeated starts, output stays high.
      for (int i = 0; i < 4; i++) begin
         drive(0, 1'b1, 1'b0, 4'hA, 1'b0);
         check($sformatf("hold%0d_pwm", i),  32'(bus.pwm_out),     1);
         check($sformatf("hold%0d_done", i), 32'(bus.period_done), 0);
         $display("hold cycle %0d: pwm=%0d done=%0d", i, bus.pwm_out, bus.period_done);
      end
      drive(0, 1'b1, 1'b1, 4'd6, 1'b0);
      check("hold_load_pwm",  32'(bus.pwm_out),      1);
      check("hold_load_pend", 32'(bus.duty_pending), 0);
      highs = 0;
      for (int c = 1; c < 16; c++) begin
         drive(c, 1'b1, 1'b0, 4'hA, 1'b0);
         if (bus.pwm_out === 1'b1) highs++;
         if (c == 15) check("hold_rel_done", 32'(bus.period_done), 1);
      end
      check("hold_rel_high", highs, 5);
      $display("hold release: high=%0d (cnt 1..15)", highs);

      // Reset at cnt=4 with a load pending and the output high.
      for (int c = 0; c < 4; c++) begin
         drive(c, 1'b1, (c == 2), (c == 2) ? 4'd7 : 4'hA, 1'b0);
         check($sformatf("pre_rst%0d_pwm", c), 32'(bus.pwm_out), 1);
      end
      check("pre_rst_pend", 32'(bus.duty_pending), 1);
      drive(4, 1'b1, 1'b0, 4'hA, 1'b1);
      check("mid_rst_pwm",    32'(bus.pwm_out),      0);
      check("mid_rst_pend",   32'(bus.duty_pending), 0);
      check("mid_rst_active", 32'(bus.active),       0);
      check("mid_rst_done",   32'(bus.period_done),  0);
      $display("mid reset: pwm=%0d pend=%0d active=%0d done=%0d",
               bus.pwm_out, bus.duty_pending, bus.active, bus.period_done);
      highs = 0;
      for (int c = 5; c < 16; c++) begin
         drive(c, 1'b1, 1'b0, 4'hA, 1'b0);
         if (bus.pwm_out === 1'b1) highs++;
      end
      check("post_rst_high",   highs,            0);
      check("post_rst_active", 32'(bus.active),  0);

      foreach (tail[i]) run_period(tail[i], $sformatf("t%0d", i));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
